// File: rtl/mat_stream_out.sv
// mat_stream_out: snapshots a flattened H x W matrix result on the rising
// edge of mat_done and streams it row-major over a valid/ready interface.
//
// Ports:
//   clk, rst   - clock, asynchronous active-high reset
//   mat_done   - level done from the multiply block
//   mat_o      - flattened result, element (0,0) in the MSBs
//   out_data   - current element
//   out_row    - row tag of out_data
//   out_col    - column tag of out_data
//   out_valid  - out_data/row/col/last valid
//   out_ready  - downstream accepts
//   out_last   - final element (H-1,W-1) of a frame
//   busy       - a frame is held / streaming
//   overrun    - sticky: a result arrived while a frame was streaming
module mat_stream_out #(
  parameter int S = 32,
  parameter int H = 2,
  parameter int W = 2,
  localparam int N  = H * W,
  localparam int RW = (H > 1) ? $clog2(H) : 1,
  localparam int CW = (W > 1) ? $clog2(W) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           mat_done,
  input  logic [S*N-1:0] mat_o,
  output logic [S-1:0]   out_data,
  output logic [RW-1:0]  out_row,
  output logic [CW-1:0]  out_col,
  output logic           out_valid,
  input  logic           out_ready,
  output logic           out_last,
  output logic           busy,
  output logic           overrun
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);
  localparam logic [CW-1:0] LAST_COL = CW'(W - 1);

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  state_t         state_q, state_d;
  logic           done_q;
  logic [S*N-1:0] shadow_q, shadow_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic [RW-1:0]  row_q, row_d;
  logic [CW-1:0]  col_q, col_d;
  logic           ovr_q, ovr_d;

  logic           rise;
  logic           is_last;
  logic           accept;
  logic [S-1:0]   elem [N];

  for (genvar k = 0; k < N; k++) begin : g_elem
    assign elem[k] = shadow_q[S*(N-k)-1 -: S];
  end

  assign rise    = mat_done & ~done_q;
  assign is_last = (idx_q == LAST_IDX);
  assign accept  = (state_q == SEND) & out_ready;

  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    idx_d    = idx_q;
    row_d    = row_q;
    col_d    = col_q;
    ovr_d    = ovr_q;
    unique case (state_q)
      IDLE: begin
        if (rise) begin
          state_d  = SEND;
          shadow_d = mat_o;
          idx_d    = '0;
          row_d    = '0;
          col_d    = '0;
        end
      end
      SEND: begin
        if (accept && is_last) begin
          idx_d = '0;
          row_d = '0;
          col_d = '0;
          // A result landing on the final beat chains straight
          // into the next frame with no idle cycle.
          if (rise) begin
            shadow_d = mat_o;
          end else begin
            state_d = IDLE;
          end
        end else begin
          if (rise) begin
            ovr_d = 1'b1;
          end
          if (accept) begin
            idx_d = idx_q + IW'(1);
            if (col_q == LAST_COL) begin
              col_d = '0;
              row_d = row_q + RW'(1);
            end else begin
              col_d = col_q + CW'(1);
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      // Starts high so a done already asserted at reset release
      // needs a fresh 0->1 edge before it is taken.
      done_q   <= 1'b1;
      shadow_q <= '0;
      idx_q    <= '0;
      row_q    <= '0;
      col_q    <= '0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      done_q   <= mat_done;
      shadow_q <= shadow_d;
      idx_q    <= idx_d;
      row_q    <= row_d;
      col_q    <= col_d;
      ovr_q    <= ovr_d;
    end
  end

  assign busy      = (state_q == SEND);
  assign out_valid = busy;
  assign out_data  = elem[idx_q];
  assign out_row   = row_q;
  assign out_col   = col_q;
  assign out_last  = busy & is_last;
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_mat_stream_out.sv
// tb_mat_stream_out: scoreboard bench for mat_stream_out, one 2x2 and
// one 3x1 instance sharing handshake and done stimulus.
module tb_mat_stream_out;

  typedef struct {
    logic [31:0] d;
    int          r;
    int          c;
    bit          l;
  } beat_t;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         mat_done = 1'b0;
  logic         out_ready = 1'b0;
  logic [127:0] mat_a = '0;
  logic [95:0]  mat_b = '0;

  logic [31:0]  da, db;
  logic         ra, ca, cb;
  logic [1:0]   rb;
  logic         va, vb, la, lb, ba, bb, oa, ob;

  beat_t qa[$];
  beat_t qb[$];
  bit    ovr_a, ovr_b;
  bit    prev_done;
  int    vecs = 0;
  int    errs = 0;

  always #5 clk = ~clk;

  mat_stream_out #(.S(32), .H(2), .W(2)) dut_a (
    .clk(clk), .rst(rst), .mat_done(mat_done),
    .mat_o(mat_a), .out_data(da), .out_row(ra),
    .out_col(ca), .out_valid(va), .out_ready(out_ready),
    .out_last(la), .busy(ba), .overrun(oa)
  );

  mat_stream_out #(.S(32), .H(3), .W(1)) dut_b (
    .clk(clk), .rst(rst), .mat_done(mat_done),
    .mat_o(mat_b), .out_data(db), .out_row(rb),
    .out_col(cb), .out_valid(vb), .out_ready(out_ready),
    .out_last(lb), .busy(bb), .overrun(ob)
  );

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Reference: element k of an n-element frame, row-major,
  // element 0 in the most significant word.
  task automatic push(input bit which, input logic [127:0] m);
    int n;
    int w;
    n = which ? 3 : 4;
    w = which ? 1 : 2;
    for (int k = 0; k < n; k++) begin
      beat_t b;
      b.d = 32'(m >> (32 * (n - 1 - k)));
      b.r = k / w;
      b.c = k % w;
      b.l = (k == n - 1);
      if (which) qb.push_back(b);
      else qa.push_back(b);
    end
  endtask

  // One clock: a rising done is taken only if no beat would remain
  // outstanding after this edge; otherwise it is an overrun.
  task automatic step(input bit rdy, input bit dn);
    bit rise, cap_a, cap_b;
    out_ready = rdy;
    mat_done  = dn;
    rise = dn && !prev_done;
    prev_done = dn;
    cap_a = rise && (qa.size() == 0 ||
                     (qa.size() == 1 && rdy));
    cap_b = rise && (qb.size() == 0 ||
                     (qb.size() == 1 && rdy));
    @(posedge clk);
    if (cap_a) push(1'b0, mat_a);
    else if (rise) ovr_a = 1'b1;
    if (cap_b) push(1'b1, 128'(mat_b));
    else if (rise) ovr_b = 1'b1;
    #1;
  endtask

  task automatic drain();
    int i;
    i = 0;
    while ((qa.size() != 0 || qb.size() != 0) && i < 40) begin
      step(1'b1, mat_done);
      i++;
    end
    chk("drain_a", 64'(qa.size()), 64'd0);
    chk("drain_b", 64'(qb.size()), 64'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_valid_a", 64'(va), 64'd0);
    chk("rst_valid_b", 64'(vb), 64'd0);
    chk("rst_busy_a", 64'(ba), 64'd0);
    chk("rst_ovr_a", 64'(oa), 64'd0);
    chk("rst_data_a", 64'(da), 64'd0);
    chk("rst_last_b", 64'(lb), 64'd0);
    qa.delete();
    qb.delete();
    ovr_a = 1'b0;
    ovr_b = 1'b0;
    prev_done = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      chk("a_valid", 64'(va), 64'(qa.size() != 0));
      chk("a_busy", 64'(ba), 64'(qa.size() != 0));
      chk("a_overrun", 64'(oa), 64'(ovr_a));
      if (va && qa.size() != 0) begin
        chk("a_data", 64'(da), 64'(qa[0].d));
        chk("a_row", 64'(ra), 64'(qa[0].r));
        chk("a_col", 64'(ca), 64'(qa[0].c));
        chk("a_last", 64'(la), 64'(qa[0].l));
        if (out_ready) void'(qa.pop_front());
      end else begin
        chk("a_last_idle", 64'(la), 64'd0);
      end
      chk("b_valid", 64'(vb), 64'(qb.size() != 0));
      chk("b_busy", 64'(bb), 64'(qb.size() != 0));
      chk("b_overrun", 64'(ob), 64'(ovr_b));
      if (vb && qb.size() != 0) begin
        chk("b_data", 64'(db), 64'(qb[0].d));
        chk("b_row", 64'(rb), 64'(qb[0].r));
        chk("b_col", 64'(cb), 64'(qb[0].c));
        chk("b_last", 64'(lb), 64'(qb[0].l));
        if (out_ready) void'(qb.pop_front());
      end else begin
        chk("b_last_idle", 64'(lb), 64'd0);
      end
    end
  end

  initial begin
    bit dn;
    bit [6:0] bp;
    #1 rst = 1'b1;
    #2;
    chk("init_valid", 64'(va), 64'd0);
    chk("init_last", 64'(la), 64'd0);
    chk("init_busy", 64'(ba), 64'd0);
    chk("init_ovr", 64'(oa), 64'd0);
    chk("init_data", 64'(da), 64'd0);
    chk("init_row", 64'(ra), 64'd0);
    chk("init_col", 64'(ca), 64'd0);
    chk("init_row_b", 64'(rb), 64'd0);
    prev_done = 1'b1;
    ovr_a = 1'b0;
    ovr_b = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;

    // basic frame, then snapshot and held done
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    mat_a = {32'h3F800000, 32'h40000000,
             32'h40400000, 32'h40800000};
    mat_b = {32'h11111111, 32'h22222222, 32'h33333333};
    step(1'b1, 1'b1);
    mat_a = '1;
    mat_b = '1;
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1);

    // backpressure 1,0,0,1,0,1,1
    mat_a = {32'h3F800000, 32'h40000000,
             32'h40400000, 32'h40800000};
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    bp = 7'b1001011;
    for (int i = 6; i >= 0; i--) step(bp[i], 1'b1);
    drain();

    // overrun while on element 1
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    mat_a = {4{32'hDEADBEEF}};
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    drain();

    // rise aligned with the last handshake of dut_a
    mat_a = {32'hA0A0A0A0, 32'hB1B1B1B1,
             32'hC2C2C2C2, 32'hD3D3D3D3};
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    mat_a = {32'h01020304, 32'h05060708,
             32'h090A0B0C, 32'h0D0E0F10};
    while (qa.size() > 1) step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    drain();

    // randomized traffic
    dn = mat_done;
    for (int i = 0; i < 400; i++) begin
      mat_a = {$urandom, $urandom, $urandom, $urandom};
      mat_b = {$urandom, $urandom, $urandom};
      if ($urandom_range(0, 4) == 0) dn = ~dn;
      step($urandom_range(0, 3) != 0, dn);
    end
    drain();

    // reset mid-frame at idx 2, done high at release
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    while (qa.size() > 2) step(1'b1, 1'b1);
    do_reset();
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    mat_a = {32'h12345678, 32'h9ABCDEF0,
             32'h0F1E2D3C, 32'h4B5A6978};
    step(1'b1, 1'b1);
    drain();
    step(1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vecs, errs);
    $finish;
  end

endmodule
